serial_sub: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single registered borrow. It is the subtraction counterpart to the half-adder arithmetic cells in the FPGA lab library. It trades W cycles of latency for a one-bit datapath, and it is built from a half-subtractor cell. It sits behind any controller that issues a `start` pulse and waits for `done`.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_sub_hs.sv | 12 +
 rtl/serial_sub.sv | 120 ++++++++++++
 tb/tb_serial_sub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Counter width for n bit positions; never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/serial_sub_hs.sv
// Half-subtractor cell: difference and borrow-out of a - b for single bits.
module hs_12 (
   input  logic a_i,
   input  logic b_i,
   output logic d_o,
   output logic bo_o
);

   assign d_o  = a_i ^ b_i;
   assign bo_o = ~a_i & b_i;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock through a full subtractor built from two half-subtractor cells.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow,
   output logic         ovf
);

   localparam int CW = cnt_width(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   state_e        state_q;
   logic [W-1:0]  sa_q;
   logic [W-1:0]  sb_q;
   logic [W-1:0]  diff_q;
   logic [CW-1:0] cnt_q;
   logic          br_q;
   logic          am_q;
   logic          bm_q;
   logic          busy_q;
   logic          done_q;
   logic          borrow_q;

   logic          d0_s;
   logic          bo0_s;
   logic          bo1_s;
   logic          bit_d;
   logic          br_d;

   hs_12 u_hs_lo (
      .a_i  (sa_q[0]),
      .b_i  (sb_q[0]),
      .d_o  (d0_s),
      .bo_o (bo0_s)
   );

   hs_12 u_hs_hi (
      .a_i  (d0_s),
      .b_i  (br_q),
      .d_o  (bit_d),
      .bo_o (bo1_s)
   );

   assign br_d = bo0_s | bo1_s;

   // Control FSM and serial datapath; DONE doubles as an accept slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sa_q     <= {W{1'b0}};
         sb_q     <= {W{1'b0}};
         diff_q   <= {W{1'b0}};
         cnt_q    <= {CW{1'b0}};
         br_q     <= 1'b0;
         am_q     <= 1'b0;
         bm_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  am_q    <= a[W-1];
                  bm_q    <= b[W-1];
                  br_q    <= 1'b0;
                  cnt_q   <= {CW{1'b0}};
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sa_q   <= {1'b0, sa_q[W-1:1]};
               sb_q   <= {1'b0, sb_q[W-1:1]};
               diff_q <= {bit_d, diff_q[W-1:1]};
               br_q   <= br_d;
               // The last bit skips the increment so cnt never wraps.
               if (cnt_q == CNT_LAST) begin
                  borrow_q <= br_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else begin
                  cnt_q    <= cnt_q + CW'(1);
                  state_q  <= ST_RUN;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign ovf    = (am_q != bm_q) && (diff_q[W-1] != am_q);

endmodule

// File: tb/tb_serial_sub.sv
// Randomized and directed scoreboard bench for serial_sub (W=8).
module tb_serial_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   serial_sub #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer arithmetic on the unsigned and signed views.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
      exp_t e;
      int ux = int'(x);
      int uy = int'(y);
      int sx = int'($signed(x));
      int sy = int'($signed(y));
      int r = sx - sy;
      e.d   = W'((ux - uy + (1 << W)) % (1 << W));
      e.br  = (ux < uy);
      e.ov  = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
      e.cyc = c;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per done pulse; tracks busy length.
   initial begin
      int busy_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("diff", int'(diff), int'(e.d));
                  check("borrow", int'(borrow), int'(e.br));
                  check("ovf", int'(ovf), int'(e.ov));
                  check("latency", cyc - e.cyc, W);
                  check("busy_cycles", busy_cnt, W);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(model(x, y, cyc));
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("done_timeout", 0, 1);
         exp_q.delete();
      end
   endtask

   task automatic wait_done_pulse(output int at_cyc);
      int n = 0;
      at_cyc = -1;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (done) begin
            at_cyc = cyc;
            break;
         end
      end
      if (at_cyc < 0) check("pulse_timeout", 0, 1);
   endtask

   initial begin
      int d1;
      int d2;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_diff", int'(diff), 0);
      check("rst_borrow", int'(borrow), 0);
      check("rst_ovf", int'(ovf), 0);
      rst = 1'b0;

      issue(8'd5, 8'd3);      wait_done();
      issue(8'd3, 8'd5);      wait_done();
      issue(8'h80, 8'h01);    wait_done();
      issue(8'h7F, 8'hFF);    wait_done();

      // start during RUN must be ignored and not queued
      issue(8'h10, 8'h20);
      repeat (3) @(negedge clk);
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      repeat (12) @(posedge clk);

      // reset mid-operation aborts with no done
      issue(8'h33, 8'h11);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_diff", int'(diff), 0);
      check("abort_borrow", int'(borrow), 0);
      rst = 1'b0;
      repeat (15) @(posedge clk);
      issue(8'd0, 8'd0);      wait_done();

      // back-to-back with start held high through DONE
      @(negedge clk);
      a = 8'd9;
      b = 8'd4;
      start = 1'b1;
      @(posedge clk);
      #1 exp_q.push_back(model(8'd9, 8'd4, cyc));
      wait_done_pulse(d1);
      a = 8'd4;
      b = 8'd9;
      @(posedge clk);
      #1 exp_q.push_back(model(8'd4, 8'd9, cyc));
      start = 1'b0;
      wait_done_pulse(d2);
      if (d1 >= 0 && d2 >= 0) check("b2b_spacing", d2 - d1, W + 1);
      wait_done();

      for (int i = 0; i < 40; i++) begin
         issue(W'($urandom), W'($urandom));
         wait_done();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
